// File: rtl/sprite_draw_engine.sv
// Sprite draw stage: background repaint or character paint of one SPR_W x SPR_H footprint, one pixel per cycle; SPRITE_DIR_FLIP_EN adds horizontal mirroring.
// Latency: request edge at c -> plots c+2..c+SPR_W*SPR_H+1, done pulse at c+SPR_W*SPR_H+2; no backpressure, every plot is accepted.
module sprite_draw_engine #(
    parameter int              SPR_W       = 8,
    parameter int              SPR_H       = 8,
    parameter int              SCR_W       = 320,
    parameter int              SCR_H       = 240,
    parameter int              CW          = 9,
    parameter logic [CW-1:0]   TRANSPARENT = 'h1C7,
    localparam int             CHR_AW      = $clog2(SPR_W*SPR_H)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              drawBG,
    input  logic              drawChar,
    input  logic [8:0]        xCoordinate,
    input  logic [7:0]        yCoordinate,
    input  logic [1:0]        dir,
    output logic [16:0]       bg_addr,
    input  logic [CW-1:0]     bg_q,
    output logic [CHR_AW-1:0] chr_addr,
    input  logic [CW-1:0]     chr_q,
    output logic              plot,
    output logic [8:0]        vga_x,
    output logic [7:0]        vga_y,
    output logic [CW-1:0]     colour,
    output logic              doneBG,
    output logic              doneChar
);

    localparam int CXW = $clog2(SPR_W);
    localparam int RYW = $clog2(SPR_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic             drawBG_q, drawChar_q;
    logic             mode_q, mode_d;
    logic [9:0]       ox_q, ox_d, oy_q, oy_d;
    logic [CXW-1:0]   col_q, col_d, chr_col;
    logic [RYW-1:0]   row_q, row_d;
    logic             s1_vld_q, s1_vld_d, s1_on_q, s1_on_d;
    logic [8:0]       s1_x_q, s1_x_d;
    logic [7:0]       s1_y_q, s1_y_d;

    logic             req_bg, req_chr, req_any, issue, last_pix, on_scr;
    logic [10:0]      px, py;
    logic             unused_dir;

    assign req_bg   = drawBG & ~drawBG_q;
    assign req_chr  = drawChar & ~drawChar_q;
    assign req_any  = req_bg | req_chr;
    assign issue    = (state_q == RUN);
    assign last_pix = (col_q == CXW'(SPR_W-1)) && (row_q == RYW'(SPR_H-1));
    assign unused_dir = ^dir;

    // Origin is signed; one extra bit keeps origin+offset from overflowing.
    assign px     = {ox_q[9], ox_q} + 11'(col_q);
    assign py     = {oy_q[9], oy_q} + 11'(row_q);
    assign on_scr = ~px[10] && (px < 11'(SCR_W)) && ~py[10] && (py < 11'(SCR_H));

`ifdef SPRITE_DIR_FLIP_EN
    logic flip_q, flip_d;
    always_comb begin
        flip_d = flip_q;
        if (state_q == IDLE && req_any) flip_d = dir[0];
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) flip_q <= 1'b0;
        else         flip_q <= flip_d;
    end
    assign chr_col = flip_q ? (CXW'(SPR_W-1) - col_q) : col_q;
`else
    assign chr_col = col_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = RUN;
            RUN:     if (last_pix) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        col_d    = col_q;
        row_d    = row_q;
        if (state_q == IDLE && req_any) begin
            mode_d = ~req_bg;
            ox_d   = 10'({1'b0, xCoordinate}) - 10'(SPR_W/2);
            oy_d   = 10'({2'b0, yCoordinate}) - 10'(SPR_H-1);
            col_d  = '0;
            row_d  = '0;
        end else if (issue) begin
            col_d = col_q + CXW'(1);
            if (col_q == CXW'(SPR_W-1)) row_d = row_q + RYW'(1);
        end
        s1_vld_d = issue;
        s1_on_d  = issue & on_scr;
        s1_x_d   = px[8:0];
        s1_y_d   = py[7:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drawBG_q   <= 1'b0;
            drawChar_q <= 1'b0;
            mode_q     <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_on_q    <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            drawBG_q   <= drawBG;
            drawChar_q <= drawChar;
            mode_q     <= mode_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            col_q      <= col_d;
            row_q      <= row_d;
            s1_vld_q   <= s1_vld_d;
            s1_on_q    <= s1_on_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
        end
    end

    always_comb begin
        bg_addr  = '0;
        chr_addr = '0;
        if (issue) begin
            chr_addr = {row_q, chr_col};
            if (on_scr) bg_addr = 17'(py[7:0]) * 17'(SCR_W) + 17'(px[8:0]);
        end
        // ROM data lines up with stage 1 because both ROMs have one cycle of latency.
        plot     = s1_vld_q & s1_on_q & ~(mode_q & (chr_q == TRANSPARENT));
        colour   = s1_vld_q ? (mode_q ? chr_q : bg_q) : '0;
        vga_x    = s1_x_q;
        vga_y    = s1_y_q;
        doneBG   = (state_q == DONE) & ~mode_q;
        doneChar = (state_q == DONE) & mode_q;
    end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Pixel-drawing stage directly downstream of the movement controller.
- On a rising edge of drawBG, repaints the sprite footprint from the background ROM; on a rising edge of drawChar, paints the character sprite from the character ROM at the controller's current X/Y.
- Writes one pixel per cycle to the 320x240 VGA frame-buffer adapter.
- Pulses doneBG or doneChar when the operation finishes.

Parameters:
- SPR_W, 8, sprite width in pixels (power of two)
- SPR_H, 8, sprite height in pixels (power of two)
- SCR_W, 320, screen width
- SCR_H, 240, screen height
- CW, 9, colour width
- TRANSPARENT, 9'h1C7, character-ROM colour that is never plotted

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- drawBG  in  1  background-repaint request (level from controller; edge-detected here)
- drawChar  in  1  character-draw request (level; edge-detected)
- xCoordinate  in  9  sprite anchor X (bottom-centre)
- yCoordinate  in  8  sprite anchor Y (bottom row)
- dir  in  2  facing direction (used only with the optional feature)
- bg_addr  out  17  background ROM address, py*SCR_W+px
- bg_q  in  CW  background ROM data, 1-cycle synchronous latency
- chr_addr  out  log2(SPR_W*SPR_H)  character ROM address, row*SPR_W+col
- chr_q  in  CW  character ROM data, 1-cycle latency
- plot  out  1  frame-buffer write enable
- vga_x  out  9  pixel X
- vga_y  out  8  pixel Y
- colour  out  CW  pixel colour
- doneBG  out  1  one-cycle pulse: background repaint complete
- doneChar  out  1  one-cycle pulse: character draw complete

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE; counters, edge registers and stage-1 registers clear.
  - plot, doneBG, doneChar = 0; vga_x, vga_y, colour, bg_addr, chr_addr = 0.
  - The interrupted operation is abandoned; no done pulse is issued for it.
- Edge detect: req_bg = drawBG & ~drawBG_q; req_chr = drawChar & ~drawChar_q. The _q registers update every cycle.
- FSM states IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On req_bg or req_chr, latch the mode (BG has priority if both are seen in the same cycle).
  - Latch origin ox = X - SPR_W/2 and oy = Y - (SPR_H-1), as 10-bit signed values.
  - Clear col/row; go to RUN.
  - A request edge that arrives outside IDLE is ignored.
- RUN:
  - Each cycle issues pixel (col,row): px = ox+col, py = oy+row.
  - col increments and wraps at SPR_W; row increments on col wrap.
  - After pixel (SPR_W-1, SPR_H-1), go to DRAIN.
- DRAIN: one cycle; the last pixel is plotted.
- DONE: one cycle; pulse doneBG or doneChar according to the latched mode.
- Address outputs:
  - Combinational from the counters.
  - bg_addr = 0 when the pixel is off-screen.
- Stage-1 register holds px, py, issued-valid and on-screen flag.
- A pixel issued in cycle t appears in cycle t+1:
  - vga_x/vga_y = stage-1 coordinates.
  - colour = bg_q (BG mode) or chr_q (char mode).
  - plot = valid & on-screen & ~(char mode & chr_q==TRANSPARENT).
- On-screen test: 0 <= px < SCR_W and 0 <= py < SCR_H. Clipped pixels still consume their cycle.
- Fixed latency: request edge seen in IDLE at cycle c -> RUN at c+1..c+SPR_W*SPR_H -> done pulse at c+SPR_W*SPR_H+2 (c+66 for 8x8).
- The done pulse is exactly one cycle even if the request level stays high. A new operation needs a fresh 0->1 edge.

Optional Feature:
- Macro SPRITE_DIR_FLIP_EN.
- Defined: dir is latched at request time. When the latched dir[0]=1, chr_addr uses column (SPR_W-1-col) (horizontal mirror). BG mode is unaffected.
- Undefined: dir is ignored; chr_addr always uses col.

Test Plan:
- BG repaint: reset, X=95, Y=221, drawBG rises at cycle c -> 64 plots covering x 91..98, y 214..221, bg_addr(91,214)=68571 on first pixel, doneBG=1 only at c+66, doneChar stays 0.
- Character draw with transparency: chr ROM has TRANSPARENT at indices 0..7 (top row), X=126, Y=68 -> 56 plots (rows y 62..68 only), doneChar at c+66.
- Clipping: X=2, Y=3 -> ox=-2, oy=-4; BG draw gives exactly 24 plots (x 0..5, y 0..3), no plot at negative coordinates, doneBG still at c+66.
- Same-cycle drawBG and drawChar edges -> BG performed; drawChar edge ignored; drawBG and drawChar held high after done -> no second operation and no second pulse.
- Reset asserted after 20 RUN cycles -> plot=0 immediately (asynchronously), no done pulse; a fresh drawChar edge after release -> full 64-cycle draw and normal doneChar.
- With SPRITE_DIR_FLIP_EN, dir=2'b01 -> first issued pixel has chr_addr=7, last has 56; with dir=2'b00 -> first 0, last 63.
